// File: rtl/paper_seq_ctrl_pkg.sv
// Shared definitions for the paper processor fetch/execute sequencer:
// opcode encodings and FSM state encoding.
package paper_seq_ctrl_pkg;

    // Instruction opcodes (upper two bits of the instruction word)
    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Sequencer states; ST_PAUSE is only reachable in single-step builds
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Program is considered running in any of these states
    function automatic logic state_is_busy(state_t s);
        return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/paper_seq_ctrl_if.sv
// Bus bundle between the sequencer, the program RAM (imem_*) and the
// accumulator datapath (acc_*). The sequencer is the master side.
interface paper_seq_ctrl_if #(
    parameter int AW = 2
);
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [AW+1:0] imem_data;
    logic          imem_valid;
    logic          acc_inc;
    logic          acc_clr;
    logic          acc_ovf;

    modport master (
        output imem_rd, imem_addr, acc_inc, acc_clr,
        input  imem_data, imem_valid, acc_ovf
    );

    modport slave (
        input  imem_rd, imem_addr, acc_inc, acc_clr,
        output imem_data, imem_valid, acc_ovf
    );
endinterface

// File: rtl/paper_seq_ctrl_pc.sv
// Program counter register for the paper sequencer.
// Control priority: clr > load > inc; increment wraps silently.
module paper_seq_pc #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          inc_i,
    input  logic [AW-1:0] load_val_i,
    output logic [AW-1:0] pc_o
);
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    // Next PC selection with clear taking precedence over load over increment
    always_comb begin
        pc_d = pc_q;
        if (clr_i)       pc_d = '0;
        else if (load_i) pc_d = load_val_i;
        else if (inc_i)  pc_d = pc_q + 1'b1;
    end

    // PC register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= '0;
        else      pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/paper_seq_ctrl.sv
// Fetch/execute sequencer for the 2-bit paper processor.
// Owns the PC (via paper_seq_pc), the instruction register and the
// retired-instruction counter; drives accumulator inc/clr pulses.
// Optional build macro: STEP_MODE_EN adds a step_i input and a PAUSE
// state after every non-halting instruction.
module paper_seq_ctrl
    import paper_seq_ctrl_pkg::*;
#(
    parameter int AW = 2,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
`ifdef STEP_MODE_EN
    input  logic            step_i,
`endif
    paper_seq_ctrl_if.master bus,
    output logic [AW-1:0]   pc_o,
    output logic            busy_o,
    output logic            halted_o,
    output logic            err_o,
    output logic [CW-1:0]   instr_cnt_o
);

`ifdef STEP_MODE_EN
    localparam state_t ST_AFTER_EXEC = ST_PAUSE;
`else
    localparam state_t ST_AFTER_EXEC = ST_FETCH;
`endif

    state_t          state_q, state_d;
    logic [AW+1:0]   ir_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;
    logic            imem_rd_q, acc_inc_q, acc_clr_q, busy_q, halted_q;

    logic            pc_clr, pc_load, pc_inc;
    logic [AW-1:0]   pc;
    logic [1:0]      opcode;
    logic [AW-1:0]   operand;
    logic            launch, fetch_done, in_exec;

    assign opcode     = ir_q[AW+1:AW];
    assign operand    = ir_q[AW-1:0];
    assign launch     = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && start_i;
    assign fetch_done = (state_q == ST_FETCH) && bus.imem_valid;
    assign in_exec    = (state_q == ST_EXEC);

    paper_seq_pc #(.AW(AW)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pc_clr),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (operand),
        .pc_o       (pc)
    );

    // Next-state and PC control decode
    always_comb begin
        state_d = state_q;
        pc_clr  = 1'b0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_clr  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.imem_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_INC: begin
                        pc_inc  = 1'b1;
                        state_d = ST_AFTER_EXEC;
                    end
                    OP_JNO: begin
                        // Overflow flag is sampled during this EXEC cycle
                        if (bus.acc_ovf) pc_inc  = 1'b1;
                        else             pc_load = 1'b1;
                        state_d = ST_AFTER_EXEC;
                    end
                    default: state_d = ST_HALT;  // HLT and illegal both stop
                endcase
            end
`ifdef STEP_MODE_EN
            ST_PAUSE: begin
                if (step_i) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            imem_rd_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            acc_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            imem_rd_q <= (state_d == ST_FETCH);
            busy_q    <= state_is_busy(state_d);
            halted_q  <= (state_d == ST_HALT);
            acc_clr_q <= launch;
            // Pulse lands in the EXEC cycle of the fetched INC
            acc_inc_q <= fetch_done && (bus.imem_data[AW+1:AW] == OP_INC);
        end
    end

    // Instruction register, error flag and saturating retired counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (fetch_done) ir_q <= bus.imem_data;
            if (launch) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end else if (in_exec) begin
                if (opcode == OP_ILL) err_q <= 1'b1;
                if (!(&cnt_q))        cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.imem_rd   = imem_rd_q;
    assign bus.imem_addr = pc;
    assign bus.acc_inc   = acc_inc_q;
    assign bus.acc_clr   = acc_clr_q;
    assign pc_o          = pc;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;
    assign instr_cnt_o   = cnt_q;

endmodule
